mem_arb_ctrl: RTL

- Scheduler for the single shared instruction/data memory of the 5-stage pipeline.
- Arbitrates between the IF-stage fetch requester and the MEM-stage load/store requester, and sequences each access through a variable-latency memory handshake.
- Generates per-stage stall requests that the pipeline stall logic ORs into its IFID/EXMEM freeze terms.
- Data has priority; a starvation guard ensures fetch progress; a timeout traps a hung memory.

---
 rtl/mem_arb_ctrl_if.sv | 39 +++
 rtl/mem_arb_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_arb_ctrl_if.sv
// Pipeline-side request/response and memory-side handshake bundle for mem_arb_ctrl.
// slave: the arbiter's view; master: the pipeline and memory environment's view.
interface mem_arb_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          i_stall;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          err;

  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, i_flush, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Shared I/D memory scheduler: data-priority grant with fetch starvation guard, kill on flush,
// timeout abort with sticky err. Issue one cycle after grant; stalls are combinational.
module mem_arb_ctrl #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  // Abort at the edge where the busy counter would reach TIMEOUT-1.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 2);

  state_t        state_q;
  logic          mem_en_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_done_q;
  logic          d_done_q;
  logic          err_q;
  logic          kill_q;
  logic [3:0]    starve_q;
  logic [7:0]    tmo_q;

  logic i_vld;
  logic force_i_d;
  logic gnt_d_d;
  logic gnt_i_d;

  assign i_vld     = bus.i_req & ~bus.i_flush;
  assign force_i_d = (starve_q == STARVE_LIM) & i_vld;
  assign gnt_d_d   = bus.d_req & ~force_i_d;
  assign gnt_i_d   = i_vld & ~gnt_d_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      kill_q      <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
    end else begin
      mem_en_q <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      if (!i_vld) starve_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_d_d) begin
            state_q     <= DBUSY;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= bus.d_wr;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            tmo_q       <= '0;
            if (i_vld && starve_q != STARVE_LIM) starve_q <= starve_q + 4'd1;
          end else if (gnt_i_d) begin
            state_q    <= IBUSY;
            mem_en_q   <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= bus.i_addr;
            tmo_q      <= '0;
            kill_q     <= 1'b0;
            starve_q   <= '0;
          end
        end
        DBUSY: begin
          if (bus.mem_done) begin
            state_q  <= IDLE;
            d_done_q <= 1'b1;
            if (!mem_wr_q) d_rdata_q <= bus.mem_rdata;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        IBUSY: begin
          if (bus.mem_done) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            if (!kill_q && !bus.i_flush) begin
              i_done_q  <= 1'b1;
              i_rdata_q <= bus.mem_rdata;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            kill_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
            if (bus.i_flush) kill_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.d_stall   = bus.d_req & ~d_done_q;
  assign bus.i_stall   = bus.i_req & ~i_done_q & ~bus.i_flush;

endmodule
